// File: rtl/bme280_sequencer_if.sv
// Wrapper-side link between the BME280 register sequencer and the I2C read wrapper.
// The sequencer selects a register, pulses en, and later samples the read result on data.
interface bme280_sequencer_if;
  logic       en;
  logic [3:0] register_selector;
  logic [7:0] data;

  modport master (output en, output register_selector, input data);
  modport slave  (input en, input register_selector, output data);
endinterface

// File: rtl/bme280_sequencer.sv
// Sweeps BME280 registers FIRST_REG..LAST_REG through an I2C read wrapper and keeps the results
// in a readable bank. Sweeps can run once or repeat after an idle interval.
module bme280_sequencer #(
  parameter int         SETUP_CYCLES    = 5,
  parameter int         EN_CYCLES       = 5,
  parameter int         WAIT_CYCLES     = 150,
  parameter int         INTERVAL_CYCLES = 1000,
  parameter logic [3:0] FIRST_REG       = 4'd0,
  parameter logic [3:0] LAST_REG        = 4'd15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      continuous,
  bme280_sequencer_if.master        wrapper,
  input  logic [3:0]                rd_addr,
  output logic [7:0]                rd_data,
  output logic                      rd_valid,
  output logic                      busy,
  output logic                      sweep_done,
  output logic [7:0]                sweep_count
);

  localparam int MAX_AB  = (SETUP_CYCLES > EN_CYCLES) ? SETUP_CYCLES : EN_CYCLES;
  localparam int MAX_CD  = (WAIT_CYCLES > INTERVAL_CYCLES) ? WAIT_CYCLES : INTERVAL_CYCLES;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] SETUP_LD    = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] EN_LD       = CNT_W'(EN_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LD     = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] INTERVAL_LD = CNT_W'(INTERVAL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    PULSE,
    WAIT,
    CAPTURE,
    DONE,
    INTERVAL
  } state_t;

  logic [1:0]       r_rstSync;
  logic             w_rstN;
  state_t           r_state;
  logic [3:0]       r_sel;
  logic [CNT_W-1:0] r_cnt;
  logic             r_en;
  logic             r_busy;
  logic             r_sweepDone;
  logic [7:0]       r_sweepCount;
  logic [7:0]       r_bank [16];
  logic [15:0]      r_valid;

  // Reset asserts immediately but releases only on a clock edge, so the FSM never sees a runt release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rstSync <= 2'b00;
    end else begin
      r_rstSync <= {r_rstSync[0], 1'b1};
    end
  end

  assign w_rstN = r_rstSync[1];

  always_ff @(posedge clk or negedge w_rstN) begin
    if (!w_rstN) begin
      r_state      <= IDLE;
      r_sel        <= FIRST_REG;
      r_cnt        <= '0;
      r_en         <= 1'b0;
      r_busy       <= 1'b0;
      r_sweepDone  <= 1'b0;
      r_sweepCount <= 8'h00;
      r_valid      <= 16'h0000;
      for (int i = 0; i < 16; i++) begin
        r_bank[i] <= 8'h00;
      end
    end else begin
      r_sweepDone <= 1'b0;
      if (stop) begin
        // Abort keeps the bank and sel; only the next start reloads FIRST_REG.
        r_state <= IDLE;
        r_en    <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              r_sel   <= FIRST_REG;
              r_cnt   <= SETUP_LD;
              r_state <= SELECT;
              r_busy  <= 1'b1;
            end
          end
          SELECT: begin
            if (r_cnt == '0) begin
              r_cnt   <= EN_LD;
              r_en    <= 1'b1;
              r_state <= PULSE;
            end else begin
              r_cnt <= r_cnt - CNT_ONE;
            end
          end
          PULSE: begin
            if (r_cnt == '0) begin
              r_cnt   <= WAIT_LD;
              r_en    <= 1'b0;
              r_state <= WAIT;
            end else begin
              r_cnt <= r_cnt - CNT_ONE;
            end
          end
          WAIT: begin
            if (r_cnt == '0) begin
              r_state <= CAPTURE;
            end else begin
              r_cnt <= r_cnt - CNT_ONE;
            end
          end
          CAPTURE: begin
            r_bank[r_sel]  <= wrapper.data;
            r_valid[r_sel] <= 1'b1;
            if (r_sel == LAST_REG) begin
              r_sweepDone  <= 1'b1;
              r_sweepCount <= r_sweepCount + 8'd1;
              r_state      <= DONE;
            end else begin
              r_sel   <= r_sel + 4'd1;
              r_cnt   <= SETUP_LD;
              r_state <= SELECT;
            end
          end
          DONE: begin
            if (continuous) begin
              r_cnt   <= INTERVAL_LD;
              r_state <= INTERVAL;
            end else begin
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end
          end
          INTERVAL: begin
            if (!continuous) begin
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end else if (r_cnt == '0) begin
              r_sel   <= FIRST_REG;
              r_cnt   <= SETUP_LD;
              r_state <= SELECT;
            end else begin
              r_cnt <= r_cnt - CNT_ONE;
            end
          end
          default: begin
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign wrapper.en                = r_en;
  assign wrapper.register_selector = r_sel;
  assign rd_data                   = r_bank[rd_addr];
  assign rd_valid                  = r_valid[rd_addr];
  assign busy                      = r_busy;
  assign sweep_done                = r_sweepDone;
  assign sweep_count               = r_sweepCount;

endmodule

// File: tb/tb_bme280_sequencer.sv
// Directed bench for bme280_sequencer at default parameters; cycle k counts negedges after the
// posedge that sampled start (k=1 is the first cycle in SELECT, DONE lands on k=2577).
module tb_bme280_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       continuous;
  logic [3:0] rdAddr;
  logic [7:0] rdData;
  logic       rdValid;
  logic       busy;
  logic       sweepDone;
  logic [7:0] sweepCount;
  logic       dataMode;
  logic [7:0] dataConst;
  int         errors;
  int         checks;

  bme280_sequencer_if bus ();

  bme280_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .continuous  (continuous),
    .wrapper     (bus),
    .rd_addr     (rdAddr),
    .rd_data     (rdData),
    .rd_valid    (rdValid),
    .busy        (busy),
    .sweep_done  (sweepDone),
    .sweep_count (sweepCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wrapper model: either a constant read result or one that encodes the selected register.
  always @(negedge clk) begin
    bus.data = dataMode ? {4'h3, bus.register_selector} : dataConst;
  end

  task automatic resetDut();
    rst = 1'b0; start = 1'b0; stop = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic startSweep();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic test_reset();
    start = 1'b0; stop = 1'b0; continuous = 1'b0; rdAddr = 4'd0;
    dataMode = 1'b0; dataConst = 8'hA5;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.en !== 1'b0) begin errors++; $display("[TB] FAIL reset_en: got %0b expected 0", bus.en); end
    checks++; if (bus.register_selector !== 4'd0) begin errors++; $display("[TB] FAIL reset_sel: got %0d expected 0", bus.register_selector); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (sweepDone !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %0b expected 0", sweepDone); end
    checks++; if (sweepCount !== 8'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", sweepCount); end
    for (int a = 0; a < 16; a++) begin
      rdAddr = 4'(a); #1;
      checks++; if (rdValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid[%0d]: got %0b expected 0", a, rdValid); end
      checks++; if (rdData !== 8'h00) begin errors++; $display("[TB] FAIL reset_data[%0d]: got %0h expected 00", a, rdData); end
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL post_release_busy: got %0b expected 0", busy); end
  endtask

  task automatic test_single_sweep();
    int   enHigh = 0;
    int   pulses = 0;
    int   firstEn = 0;
    int   doneAt = 0;
    int   doneCnt = 0;
    logic prevEn = 1'b0;
    dataMode = 1'b0; dataConst = 8'hA5;
    startSweep();
    for (int k = 1; k <= 2590; k++) begin
      if (bus.en) begin
        enHigh++;
        if (!prevEn) begin
          if (firstEn == 0) firstEn = k;
          checks++;
          if (bus.register_selector !== 4'(pulses)) begin
            errors++; $display("[TB] FAIL pulse_sel[%0d]: got %0d expected %0d", pulses, bus.register_selector, pulses);
          end
          pulses++;
        end
      end
      prevEn = bus.en;
      if (sweepDone) begin doneCnt++; if (doneAt == 0) doneAt = k; end
      if (k == 2) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL sweep_busy: got %0b expected 1", busy); end
      end
      @(negedge clk);
    end
    checks++; if (enHigh !== 80) begin errors++; $display("[TB] FAIL en_cycles: got %0d expected 80", enHigh); end
    checks++; if (pulses !== 16) begin errors++; $display("[TB] FAIL en_pulses: got %0d expected 16", pulses); end
    checks++; if (firstEn !== 6) begin errors++; $display("[TB] FAIL first_en: got %0d expected 6", firstEn); end
    checks++; if (doneAt !== 2577) begin errors++; $display("[TB] FAIL done_time: got %0d expected 2577", doneAt); end
    checks++; if (doneCnt !== 1) begin errors++; $display("[TB] FAIL done_width: got %0d expected 1", doneCnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL end_idle: got %0b expected 0", busy); end
    checks++; if (sweepCount !== 8'd1) begin errors++; $display("[TB] FAIL count_one: got %0d expected 1", sweepCount); end
    for (int a = 0; a < 16; a++) begin
      rdAddr = 4'(a); #1;
      checks++; if (rdValid !== 1'b1) begin errors++; $display("[TB] FAIL sweep_valid[%0d]: got %0b expected 1", a, rdValid); end
    end
    rdAddr = 4'd3; #1;
    checks++; if (rdData !== 8'hA5) begin errors++; $display("[TB] FAIL sweep_data3: got %0h expected a5", rdData); end
  endtask

  task automatic test_capture();
    int doneAt = 0;
    dataMode = 1'b1; rdAddr = 4'd2;
    startSweep();
    for (int k = 1; k <= 2590; k++) begin
      // Register 2 is captured in cycle 3*161=483; the read port shows it one cycle later.
      if (k == 483) begin
        checks++; if (rdData !== 8'hA5) begin errors++; $display("[TB] FAIL capture_before: got %0h expected a5", rdData); end
      end
      if (k == 484) begin
        checks++; if (rdData !== 8'h32) begin errors++; $display("[TB] FAIL capture_after: got %0h expected 32", rdData); end
      end
      if (sweepDone && doneAt == 0) doneAt = k;
      @(negedge clk);
    end
    checks++; if (doneAt !== 2577) begin errors++; $display("[TB] FAIL capture_done: got %0d expected 2577", doneAt); end
    rdAddr = 4'd7; #1;
    checks++; if (rdData !== 8'h37) begin errors++; $display("[TB] FAIL capture_r7: got %0h expected 37", rdData); end
    rdAddr = 4'd15; #1;
    checks++; if (rdData !== 8'h3F) begin errors++; $display("[TB] FAIL capture_r15: got %0h expected 3f", rdData); end
    rdAddr = 4'd0; #1;
    checks++; if (rdData !== 8'h30) begin errors++; $display("[TB] FAIL capture_r0: got %0h expected 30", rdData); end
    checks++; if (sweepCount !== 8'd2) begin errors++; $display("[TB] FAIL count_two: got %0d expected 2", sweepCount); end
    dataMode = 1'b0;
  endtask

  task automatic test_reset_mid();
    // Register 9 occupies cycles 1450..1610; its WAIT runs 1460..1609.
    startSweep();
    repeat (1499) @(negedge clk);
    rdAddr = 4'd0; #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL mid_busy_pre: got %0b expected 1", busy); end
    checks++; if (rdValid !== 1'b1) begin errors++; $display("[TB] FAIL mid_valid_pre: got %0b expected 1", rdValid); end
    checks++; if (bus.register_selector !== 4'd9) begin errors++; $display("[TB] FAIL mid_sel_pre: got %0d expected 9", bus.register_selector); end
    #1 rst = 1'b0;
    #1;
    checks++; if (bus.en !== 1'b0) begin errors++; $display("[TB] FAIL mid_en: got %0b expected 0", bus.en); end
    checks++; if (bus.register_selector !== 4'd0) begin errors++; $display("[TB] FAIL mid_sel: got %0d expected 0", bus.register_selector); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_busy: got %0b expected 0", busy); end
    checks++; if (sweepDone !== 1'b0) begin errors++; $display("[TB] FAIL mid_done: got %0b expected 0", sweepDone); end
    checks++; if (sweepCount !== 8'd0) begin errors++; $display("[TB] FAIL mid_count: got %0d expected 0", sweepCount); end
    for (int a = 0; a < 16; a++) begin
      rdAddr = 4'(a); #1;
      checks++; if (rdValid !== 1'b0) begin errors++; $display("[TB] FAIL mid_valid[%0d]: got %0b expected 0", a, rdValid); end
    end
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    // Reset during PULSE must pull en low without a clock edge.
    startSweep();
    repeat (6) @(negedge clk);
    checks++; if (bus.en !== 1'b1) begin errors++; $display("[TB] FAIL pulse_en_pre: got %0b expected 1", bus.en); end
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.en !== 1'b0) begin errors++; $display("[TB] FAIL pulse_en_async: got %0b expected 0", bus.en); end
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_continuous();
    int doneAt [4];
    int doneN = 0;
    int enGap = 0;
    for (int i = 0; i < 4; i++) doneAt[i] = 0;
    continuous = 1'b1;
    startSweep();
    for (int k = 1; k <= 9800; k++) begin
      if (sweepDone) begin
        if (doneN < 4) doneAt[doneN] = k;
        doneN++;
      end
      if (k >= 2578 && k <= 3577 && bus.en) enGap++;
      if (k == 9732) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL cont_idle: got %0b expected 0", busy); end
      end
      if (k == 8000) continuous = 1'b0;
      @(negedge clk);
    end
    checks++; if (doneN !== 3) begin errors++; $display("[TB] FAIL cont_sweeps: got %0d expected 3", doneN); end
    checks++; if (doneAt[0] !== 2577) begin errors++; $display("[TB] FAIL cont_done1: got %0d expected 2577", doneAt[0]); end
    checks++; if (doneAt[1] !== 6154) begin errors++; $display("[TB] FAIL cont_done2: got %0d expected 6154", doneAt[1]); end
    checks++; if (doneAt[2] !== 9731) begin errors++; $display("[TB] FAIL cont_done3: got %0d expected 9731", doneAt[2]); end
    checks++; if (enGap !== 0) begin errors++; $display("[TB] FAIL cont_gap_en: got %0d expected 0", enGap); end
    checks++; if (sweepCount !== 8'd3) begin errors++; $display("[TB] FAIL cont_count: got %0d expected 3", sweepCount); end
  endtask

  task automatic test_stop();
    // Register 4 PULSE covers cycles 650..654.
    resetDut();
    startSweep();
    repeat (650) @(negedge clk);
    checks++; if (bus.en !== 1'b1) begin errors++; $display("[TB] FAIL stop_en_pre: got %0b expected 1", bus.en); end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checks++; if (bus.en !== 1'b0) begin errors++; $display("[TB] FAIL stop_en: got %0b expected 0", bus.en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL stop_busy: got %0b expected 0", busy); end
    checks++; if (bus.register_selector !== 4'd4) begin errors++; $display("[TB] FAIL stop_sel: got %0d expected 4", bus.register_selector); end
    checks++; if (sweepCount !== 8'd0) begin errors++; $display("[TB] FAIL stop_count: got %0d expected 0", sweepCount); end
    for (int a = 0; a < 16; a++) begin
      rdAddr = 4'(a); #1;
      checks++;
      if (rdValid !== ((a < 4) ? 1'b1 : 1'b0)) begin
        errors++; $display("[TB] FAIL stop_valid[%0d]: got %0b expected %0b", a, rdValid, (a < 4));
      end
    end
    startSweep();
    checks++; if (bus.register_selector !== 4'd0) begin errors++; $display("[TB] FAIL restart_sel: got %0d expected 0", bus.register_selector); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL restart_busy: got %0b expected 1", busy); end
    repeat (5) @(negedge clk);
    checks++; if (bus.en !== 1'b1) begin errors++; $display("[TB] FAIL restart_en: got %0b expected 1", bus.en); end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic test_start_stop_idle();
    int   rise = 0;
    logic [3:0] selRise = 4'd0;
    logic prevEn = 1'b0;
    @(negedge clk); start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL startstop_busy: got %0b expected 0", busy); end
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL startstop_busy_late: got %0b expected 0", busy); end
    // A start in register 1's WAIT must not disturb register 2's PULSE at cycle 328.
    startSweep();
    repeat (199) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 201; k <= 340; k++) begin
      if (bus.en && !prevEn && rise == 0) begin rise = k; selRise = bus.register_selector; end
      prevEn = bus.en;
      @(negedge clk);
    end
    checks++; if (rise !== 328) begin errors++; $display("[TB] FAIL wait_start_timing: got %0d expected 328", rise); end
    checks++; if (selRise !== 4'd2) begin errors++; $display("[TB] FAIL wait_start_sel: got %0d expected 2", selRise); end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic test_interval_exit();
    continuous = 1'b1;
    startSweep();
    repeat (2599) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL interval_busy: got %0b expected 1", busy); end
    checks++; if (sweepCount !== 8'd1) begin errors++; $display("[TB] FAIL interval_count: got %0d expected 1", sweepCount); end
    continuous = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL interval_exit: got %0b expected 0", busy); end
    repeat (5) @(negedge clk);
    checks++; if (bus.en !== 1'b0) begin errors++; $display("[TB] FAIL interval_en: got %0b expected 0", bus.en); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single_sweep();
    test_capture();
    test_reset_mid();
    test_continuous();
    test_stop();
    test_start_stop_idle();
    test_interval_exit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bme280_sequencer.md
BME280_SEQUENCER -- requirements
Module: bme280_sequencer

Interface
REQ-001 SHALL have parameter SETUP_CYCLES, default 5: cycles register_selector is held stable before en rises.
REQ-002 SHALL have parameter EN_CYCLES, default 5: width of the en pulse to the I2C wrapper.
REQ-003 SHALL have parameter WAIT_CYCLES, default 150: cycles from en falling to data capture.
REQ-004 SHALL have parameter INTERVAL_CYCLES, default 1000: idle gap between sweeps in continuous mode.
REQ-005 SHALL have parameters FIRST_REG, default 0, and LAST_REG, default 15; both are 4-bit and FIRST_REG <= LAST_REG.
REQ-006 SHALL have one clock and an asynchronous, active-low reset: clk input 1 (system clock); rst input 1 (active-low asynchronous reset).
REQ-007 SHALL have ports: start input 1 (sweep request pulse); stop input 1 (abort); continuous input 1 (repeat sweeps).
REQ-008 SHALL have wrapper-side ports: en output 1; register_selector output 4; data input 8 (wrapper read result).
REQ-009 SHALL have readout ports: rd_addr input 4; rd_data output 8; rd_valid output 1.
REQ-010 SHALL have status ports: busy output 1; sweep_done output 1 (one-cycle pulse); sweep_count output 8.

Function
REQ-011 SHALL implement states IDLE, SELECT, PULSE, WAIT, CAPTURE, DONE and INTERVAL.
REQ-012 IDLE: on start=1 and stop=0, SHALL load sel=FIRST_REG and enter SELECT on the next edge; otherwise it stays in IDLE.
REQ-013 SELECT SHALL last SETUP_CYCLES cycles with register_selector=sel and en=0, then go to PULSE.
REQ-014 PULSE SHALL last EN_CYCLES cycles with en=1, then go to WAIT.
REQ-015 WAIT SHALL last WAIT_CYCLES cycles with en=0, then go to CAPTURE.
REQ-016 CAPTURE SHALL be exactly one cycle.
REQ-017 In CAPTURE, the block SHALL write data into bank[sel] and set valid[sel].
REQ-018 After CAPTURE: if sel==LAST_REG, go to DONE; otherwise sel=sel+1 and go to SELECT.
REQ-019 Each register SHALL therefore take SETUP_CYCLES+EN_CYCLES+WAIT_CYCLES+1 cycles (161 with defaults).
REQ-020 DONE SHALL be one cycle with sweep_done=1 and sweep_count incremented modulo 256 (255 wraps to 0).
REQ-021 From DONE: if continuous=1, go to INTERVAL; otherwise go to IDLE.
REQ-022 INTERVAL SHALL count INTERVAL_CYCLES cycles, then load sel=FIRST_REG and enter SELECT.
REQ-023 In INTERVAL, continuous=0 SHALL return the FSM to IDLE on the next edge.
REQ-024 continuous deasserted mid-sweep SHALL NOT truncate the sweep; only the next-state decision in DONE uses it.
REQ-025 register_selector SHALL equal sel in every state and SHALL change only on transitions into SELECT.
REQ-026 en SHALL be 1 only in PULSE and SHALL be registered and glitch-free.
REQ-027 start while not in IDLE SHALL be ignored.
REQ-028 stop=1 in any state SHALL force IDLE on the next edge and drive en=0 from that edge.
REQ-029 On stop, bank contents and valid bits SHALL be kept, the in-progress capture is dropped, and sweep_count is unchanged.
REQ-030 start=1 and stop=1 in the same cycle: stop SHALL win and the FSM stays in IDLE.
REQ-031 rd_data=bank[rd_addr] and rd_valid=valid[rd_addr], combinational.
REQ-032 A CAPTURE to the same address as rd_addr SHALL appear on rd_data the cycle after CAPTURE.
REQ-033 busy SHALL be 0 in IDLE and 1 in all other states.
REQ-034 All counters SHALL be sized from their parameters with no overflow; a parameter value of 0 is illegal.

Reset
REQ-035 When rst=0, asynchronously: state=IDLE, sel=FIRST_REG, en=0, register_selector=FIRST_REG, busy=0, sweep_done=0, sweep_count=0.
REQ-036 When rst=0, asynchronously: all bank entries=8'h00 and all valid bits=0.
REQ-037 Reset asserted mid-transaction SHALL drop en immediately, without waiting for a clock edge.
REQ-038 Reset release SHALL be synchronous to clk, and the first transition out of IDLE SHALL occur no earlier than the first edge after release.

Verification
REQ-039 Single sweep, defaults, data tied to 8'hA5, one start pulse -> en high for 5 cycles per register, 16 pulses with register_selector 0..15; sweep_done 2577 cycles after the start edge; sweep_count=1; rd_valid=1 for every rd_addr; FSM ends in IDLE.
REQ-040 Capture check: data driven to {4'h3, register_selector} during WAIT -> rd_data at rd_addr=7 is 8'h37 and at rd_addr=15 is 8'h3F.
REQ-041 Continuous mode, continuous=1 for three sweeps then 0 -> 1000-cycle gap between sweeps, sweep_count=3, return to IDLE.
REQ-042 stop during PULSE of register 4 -> en=0 on the next edge; valid[0..3]=1, valid[4..15]=0; busy=0; a subsequent start restarts at register 0.
REQ-043 start and stop together in IDLE -> FSM stays in IDLE; start during WAIT -> ignored and timing unchanged.
REQ-044 rst pulled low mid-WAIT of register 9 -> all outputs at reset values asynchronously; sweep_count=0; rd_valid=0 for every address.
